// File: rtl/mvau_weight_stream_loader.sv
// Streams SIMD*TW-bit weight words from AXI4-Stream into one PE weight memory, addresses 0..WMEM_DEPTH-1.
// Optional macro MVAU_WLOAD_TLAST_CHECK_EN enables tlast framing checks on load_err; otherwise load_err is 0.
module mvau_weight_stream_loader #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    load_start,
    input  logic [SIMD*TW-1:0]      s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic                    wmem_wr_en,
    output logic [WMEM_ADDR_BW-1:0] wmem_wr_addr,
    output logic [SIMD*TW-1:0]      wmem_wr_data,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [1:0]              r_state;
    logic [WMEM_ADDR_BW-1:0] r_cnt;
    logic                    r_tready;
    logic                    r_wr_en;
    logic [WMEM_ADDR_BW-1:0] r_wr_addr;
    logic [SIMD*TW-1:0]      r_wr_data;
    logic                    r_done;

    logic w_hs;
    logic w_at_last;
    logic w_last_hs;
    logic w_start;

    // Handshake: valid/ready both high at a rising edge transfers one word; ready is only ever high in LOAD.
    assign w_hs      = s_axis_tvalid & r_tready;
    assign w_at_last = (r_cnt == LAST_ADDR);
    assign w_last_hs = w_hs & w_at_last;
    assign w_start   = load_start & (r_state != S_LOAD);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tready  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= w_hs;
            if (w_hs) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= s_axis_tdata;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_tready <= 1'b0;
                    if (w_start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Ready rises one cycle after entry and drops on the edge that takes the final word.
                    r_tready <= ~w_last_hs;
                    if (w_hs) begin
                        r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
                    end
                    if (w_last_hs) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tready <= 1'b0;
                end
            endcase
        end
    end

`ifdef MVAU_WLOAD_TLAST_CHECK_EN
    logic r_err;

    // Error when tlast disagrees with "this is the final word"; early tlast does not abort the load.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_hs && (s_axis_tlast != w_at_last)) begin
            r_err <= 1'b1;
        end
    end

    assign load_err = r_err;
`else
    logic w_unused_tlast;

    assign w_unused_tlast = s_axis_tlast;
    assign load_err       = 1'b0;
`endif

    assign s_axis_tready = r_tready;
    assign wmem_wr_en    = r_wr_en;
    assign wmem_wr_addr  = r_wr_addr;
    assign wmem_wr_data  = r_wr_data;
    assign load_busy     = (r_state == S_LOAD);
    assign load_done     = r_done;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_mvau_weight_stream_loader.sv
// Directed bench for mvau_weight_stream_loader: driver pushes expected {cycle, addr, data} per accepted word,
// a negedge monitor pops and compares on every memory write.
module tb_mvau_weight_stream_loader;

    localparam int SIMD = 2;
    localparam int TW   = 1;
    localparam int DEPTH = 4;
    localparam int ABW  = 4;
    localparam int W    = 16 + ABW + SIMD*TW;

`ifdef MVAU_WLOAD_TLAST_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic                 load_start;
    logic [SIMD*TW-1:0]   s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tlast;
    logic                 s_axis_tready;
    logic                 wmem_wr_en;
    logic [ABW-1:0]       wmem_wr_addr;
    logic [SIMD*TW-1:0]   wmem_wr_data;
    logic                 load_busy;
    logic                 load_done;
    logic                 load_err;
    logic [1:0]           dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0]   exp_q[$];
    logic [ABW-1:0] exp_addr;

    mvau_weight_stream_loader #(
        .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .load_start(load_start),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .wmem_wr_en(wmem_wr_en), .wmem_wr_addr(wmem_wr_addr),
        .wmem_wr_data(wmem_wr_data), .load_busy(load_busy), .load_done(load_done),
        .load_err(load_err), .dbg_state(dbg_state)
    );

    // clock / cycle stamp
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && wmem_wr_en === 1'b1) begin
            logic [W-1:0] got;
            logic [W-1:0] exp;
            got = {16'(cyc), wmem_wr_addr, wmem_wr_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got cyc=%0d addr=%0d data=%0h, no write expected",
                         cyc, wmem_wr_addr, wmem_wr_data);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL write: got cyc=%0d addr=%0d data=%0h expected cyc=%0d addr=%0d data=%0h",
                             got[W-1 -: 16], got[SIMD*TW +: ABW], got[SIMD*TW-1:0],
                             exp[W-1 -: 16], exp[SIMD*TW +: ABW], exp[SIMD*TW-1:0]);
                end
            end
        end
    end

    // driver tasks (called at a negedge)
    task automatic pulse_start(input bit accepted);
        load_start = 1'b1;
        if (accepted) exp_addr = '0;
        @(negedge aclk);
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [SIMD*TW-1:0] d, input logic l);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        while (s_axis_tready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tready never rose within 20 cycles, data=%0h", d);
            s_axis_tvalid = 1'b0;
        end else begin
            exp_q.push_back({16'(cyc + 1), exp_addr, d});
            exp_addr = (exp_addr == ABW'(DEPTH - 1)) ? '0 : exp_addr + 1'b1;
            @(negedge aclk);
        end
    endtask

    task automatic gap(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(negedge aclk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tready"}, 32'(s_axis_tready), 0);
        chk({tag, "_wr_en"},  32'(wmem_wr_en), 0);
        chk({tag, "_addr"},   32'(wmem_wr_addr), 0);
        chk({tag, "_data"},   32'(wmem_wr_data), 0);
        chk({tag, "_busy"},   32'(load_busy), 0);
        chk({tag, "_done"},   32'(load_done), 0);
        chk({tag, "_err"},    32'(load_err), 0);
        chk({tag, "_state"},  32'(dbg_state), 0);
    endtask

    initial begin
        aresetn = 1'b0; load_start = 1'b0; s_axis_tdata = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; exp_addr = '0;
        repeat (2) @(negedge aclk);
        chk_reset_outputs("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        // basic load
        pulse_start(1);
        chk("entry_busy", 32'(load_busy), 1);
        chk("entry_tready", 32'(s_axis_tready), 0);
        chk("entry_state", 32'(dbg_state), 1);
        send_word(2'h1, 0); send_word(2'h2, 0); send_word(2'h3, 0); send_word(2'h0, 1);
        gap(0);
        chk("basic_done", 32'(load_done), 1);
        chk("basic_tready", 32'(s_axis_tready), 0);
        chk("basic_busy", 32'(load_busy), 0);
        chk("basic_state", 32'(dbg_state), 2);
        gap(2);

        // reload from DONE with tvalid pattern 1,0,0,1,0,1,1
        pulse_start(1);
        chk("reload_done_drop", 32'(load_done), 0);
        send_word(2'h2, 0); gap(2); send_word(2'h1, 0); gap(1);
        send_word(2'h3, 0); send_word(2'h0, 1);
        gap(0);
        chk("gaps_done", 32'(load_done), 1);
        s_axis_tvalid = 1'b1; s_axis_tdata = 2'h2;
        for (int i = 0; i < 4; i++) begin
            chk("extra_word_tready", 32'(s_axis_tready), 0);
            @(negedge aclk);
        end
        gap(1);

        // start ignored mid-load, then start coincident with the final handshake
        pulse_start(1);
        send_word(2'h1, 0);
        gap(0);
        pulse_start(0);
        chk("ignored_start_busy", 32'(load_busy), 1);
        send_word(2'h2, 0); send_word(2'h3, 0);
        load_start = 1'b1;
        send_word(2'h0, 1);
        load_start = 1'b0;
        gap(0);
        chk("coincident_done", 32'(load_done), 1);
        chk("coincident_busy", 32'(load_busy), 0);
        chk("good_frame_err", 32'(load_err), 0);
        gap(2);

        // early tlast on word 2, missing tlast on word 4
        pulse_start(1);
        send_word(2'h1, 0); send_word(2'h2, 1);
        chk("early_tlast_err", 32'(load_err), 32'(ERR_EXP));
        send_word(2'h3, 0); send_word(2'h0, 0);
        gap(0);
        chk("early_tlast_done", 32'(load_done), 1);
        chk("err_sticky", 32'(load_err), 32'(ERR_EXP));
        gap(1);
        pulse_start(1);
        chk("start_clears_err", 32'(load_err), 0);
        send_word(2'h3, 0); send_word(2'h3, 0); send_word(2'h1, 0); send_word(2'h2, 1);
        gap(0);
        chk("correct_frame_err", 32'(load_err), 0);
        gap(1);

        // only the final tlast missing
        pulse_start(1);
        send_word(2'h0, 0); send_word(2'h1, 0); send_word(2'h2, 0);
        chk("pre_final_err", 32'(load_err), 0);
        send_word(2'h3, 0);
        gap(0);
        chk("missing_tlast_err", 32'(load_err), 32'(ERR_EXP));
        gap(1);

        // reset mid-load, then restart from address 0
        pulse_start(1);
        send_word(2'h2, 0); send_word(2'h1, 0);
        gap(1);
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        pulse_start(1);
        send_word(2'h3, 0); send_word(2'h2, 0); send_word(2'h1, 0); send_word(2'h0, 1);
        gap(0);
        chk("after_reset_done", 32'(load_done), 1);

        gap(3);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvau_weight_stream_loader.md
Name: mvau_weight_stream_loader

Overview:
- Writer-side counterpart of the MVAU weight memory read path.
- Accepts weight words over an AXI4-Stream slave and writes them sequentially into one PE's weight memory, addresses 0..WMEM_DEPTH-1.
- Sits between the host/DMA weight stream and the weight RAM write port. Reports load completion and framing errors to the MVAU control logic.

Parameters:
- SIMD, 2, number of weights per memory word.
- TW, 1, weight bit width.
- WMEM_DEPTH, 4, number of words in the target weight memory; must be >= 2.
- WMEM_ADDR_BW, 4, address width; must satisfy 2^WMEM_ADDR_BW >= WMEM_DEPTH.

Ports:
- aclk  input  1  main clock, all logic rising-edge.
- aresetn  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle pulse; arms a new load.
- s_axis_tdata  input  SIMD*TW  weight word.
- s_axis_tvalid  input  1  stream data valid.
- s_axis_tlast  input  1  stream end-of-frame marker.
- s_axis_tready  output  1  loader ready to accept a word.
- wmem_wr_en  output  1  weight memory write enable.
- wmem_wr_addr  output  WMEM_ADDR_BW  weight memory write address.
- wmem_wr_data  output  SIMD*TW  weight memory write data.
- load_busy  output  1  high while in LOAD.
- load_done  output  1  high in DONE, until the next load_start.
- load_err  output  1  sticky framing error flag.

Behaviour:
- Reset (aresetn low, asynchronous): state=IDLE; all outputs 0; word counter=0. Reset asserted mid-load abandons the load; the partial memory contents are not cleared.
- States and transitions:
  - IDLE: load_start -> LOAD with counter cleared.
  - LOAD: counter advances only on a handshake. Handshake = s_axis_tvalid & s_axis_tready in the same cycle. The handshake at counter = WMEM_DEPTH-1 -> DONE.
  - DONE: load_start -> LOAD with counter cleared, load_done cleared, load_err cleared.
- load_start is ignored while in LOAD. In IDLE and DONE, load_start also clears load_err.
- s_axis_tready:
  - Registered.
  - Goes high the cycle after entry to LOAD.
  - Stays high throughout LOAD.
  - Drops in the same cycle the last handshake registers, so exactly WMEM_DEPTH words are accepted.
  - Low in IDLE and DONE; extra words remain back-pressured.
- Write path:
  - 1-cycle latency. A handshake in cycle N gives wmem_wr_en=1 in cycle N+1, with wmem_wr_addr = the counter value at N and wmem_wr_data = tdata at N.
  - wmem_wr_en is 0 in all other cycles. Addr and data hold their last value when wr_en=0.
- Counter: WMEM_ADDR_BW wide, increments by 1 per handshake, returns to 0 after WMEM_DEPTH-1. It never exceeds WMEM_DEPTH-1, even when WMEM_DEPTH < 2^WMEM_ADDR_BW.
- tvalid gaps: no write occurs and the counter holds. Data is never accepted while tready=0.
- load_busy = (state==LOAD). load_done goes high the cycle the state enters DONE; the final write (wr_en) occurs in that same cycle.
- Simultaneous load_start and a handshake in the last LOAD cycle: the handshake completes, load_start is ignored, and the block ends in DONE.

Optional Feature:
- Macro: MVAU_WLOAD_TLAST_CHECK_EN.
- Defined:
  - load_err is set on a handshake with tlast=1 at counter != WMEM_DEPTH-1.
  - load_err is also set on the final handshake if its tlast=0.
  - On an early tlast, the word is still written and loading continues; no abort.
  - load_err is sticky until load_start or reset.
- Undefined: tlast is ignored and load_err is tied to 0.

Test Plan:
- Basic load, WMEM_DEPTH=4, SIMD=2, TW=1: reset, pulse load_start, stream 0x1,0x2,0x3,0x0 with tvalid held high -> four writes at addr 0,1,2,3 with matching data on consecutive cycles; load_done=1 and tready=0 after the 4th handshake.
- Back-pressure and gaps: tvalid toggles 1,0,0,1,0,1,1 -> writes occur only one cycle after each handshake; addresses contiguous 0..3; a 5th offered word is never accepted (tready stays 0).
- Reset mid-load: assert aresetn=0 after 2 handshakes -> all outputs 0 immediately. After release, a new load_start writes starting from addr 0.
- Reload: in DONE, pulse load_start and stream 4 new words -> load_done drops the next cycle, addresses restart at 0, and load_done returns high after the 4th word.
- Ignored start: pulse load_start during LOAD after 1 handshake -> the counter is unaffected and the remaining writes go to addr 1..3.
- With MVAU_WLOAD_TLAST_CHECK_EN defined: tlast=1 on the 2nd word -> load_err=1 the following cycle while loading continues to addr 3. A correct load (tlast only on the 4th word) -> load_err=0. The next load_start clears load_err.
